// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, imem req/gnt/rvalid handshake, {inst, pc} to the F/D register.
// Latency: zero-wait memory gives the instruction on the outputs two cycles after its request; one per cycle steady state.
// Backpressure: stall holds OUT, a one-entry skid catches the in-flight word and blocks new requests; redirect flushes everything.
//
// Ports: clk/rst (async active-high); stall, redirect, redirect_pc from pipeline control;
//        imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to instruction memory;
//        inst/pc/fetch_valid registered outputs to the F/D pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] BUBBLE   = 32'hffffffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_valid
);

    // REQ: nothing outstanding. WAIT: one request outstanding.
    // DROP: one request outstanding whose response must be discarded.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        hs;
    logic        resp;

    assign imem_addr = pc_q;
    assign hs        = imem_req && imem_gnt;
    // Responses only count while a live request is outstanding; redirect
    // takes priority in the register update below.
    assign resp      = (state == S_WAIT) && imem_rvalid;

    // Request generation. In WAIT a new request may only be issued in the
    // cycle the previous response lands, and only if that response has
    // somewhere to go (OUT drains this edge, or OUT is empty) - this is what
    // keeps the skid slot from ever overflowing.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            S_REQ:   imem_req = !skid_valid;
            S_WAIT:  imem_req = imem_rvalid && !skid_valid &&
                                (!fetch_valid || !stall) && !redirect;
            default: imem_req = 1'b0;
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (hs) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = hs ? S_WAIT : S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        // After a redirect, anything still in flight belongs to the old path.
        if (redirect) begin
            if (((state == S_WAIT || state == S_DROP) && !imem_rvalid) || hs) begin
                state_nxt = S_DROP;
            end else begin
                state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc      <= 32'h0;
            fetch_valid <= 1'b0;
            inst        <= BUBBLE;
            pc          <= 32'h0;
            skid_valid  <= 1'b0;
            skid_inst   <= BUBBLE;
            skid_pc     <= 32'h0;
        end else begin
            state <= state_nxt;

            if (hs) begin
                req_pc <= pc_q;
            end

            if (redirect) begin
                pc_q <= redirect_pc;
            end else if (hs) begin
                pc_q <= pc_q + 32'd4;
            end

            if (redirect) begin
                fetch_valid <= 1'b0;
                inst        <= BUBBLE;
                pc          <= 32'h0;
                skid_valid  <= 1'b0;
            end else if (!stall) begin
                // OUT is consumed: refill from skid first (it is older than
                // any response), else from the arriving response, else bubble.
                if (skid_valid) begin
                    fetch_valid <= 1'b1;
                    inst        <= skid_inst;
                    pc          <= skid_pc;
                    skid_valid  <= 1'b0;
                end else if (resp) begin
                    fetch_valid <= 1'b1;
                    inst        <= imem_rdata;
                    pc          <= req_pc;
                end else begin
                    fetch_valid <= 1'b0;
                    inst        <= BUBBLE;
                    pc          <= 32'h0;
                end
            end else if (resp) begin
                // Held: an empty OUT can still be filled; a full one spills to skid.
                if (fetch_valid) begin
                    skid_valid <= 1'b1;
                    skid_inst  <= imem_rdata;
                    skid_pc    <= req_pc;
                end else begin
                    fetch_valid <= 1'b1;
                    inst        <= imem_rdata;
                    pc          <= req_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected PCs, a monitor
// pops on every consumed output, and a small memory model answers requests with
// rdata = addr ^ KEY after a programmable latency and a granted-request budget.
module tb_fetch_unit;

    localparam logic [31:0] KEY    = 32'hA500_0000;
    localparam logic [31:0] BUBBLE = 32'hffffffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] addr_q[$];
    int          lat = 1;
    int          grant_total = 0;
    int          used = 0;
    int          mem_cyc = 0;

    assign imem_gnt = (grant_total > used);

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0),
        .BUBBLE   (32'hffffffff)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .fetch_valid (fetch_valid)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for OUT to present a given PC; returns at that negedge.
    task automatic wait_out(input string name, input logic [31:0] want);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (fetch_valid === 1'b1 && pc === want) found = 1'b1;
        end
        check1(name, found, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        check1(name, done, 1'b1);
    endtask

    // Memory model: accepts sampled mid-cycle, response delivered 'lat' cycles later.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_gnt;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (acc) begin
                due_q.push_back(mem_cyc + lat);
                addr_q.push_back(acc_addr);
                used++;
            end
            mem_cyc++;
            if (due_q.size() != 0 && due_q[0] == mem_cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = addr_q[0] ^ KEY;
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end
        end
    end

    // Monitor: an output is consumed when it is valid and neither held nor flushed.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (fetch_valid === 1'b1) begin
                if (!stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        check32("unexpected_out_pc", pc, 32'hxxxxxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check32("out_pc", pc, e);
                        check32("out_inst", inst, e ^ KEY);
                    end
                end
            end else begin
                check32("bubble_inst", inst, BUBBLE);
                check32("bubble_pc", pc, 32'h0);
            end
        end
    end

    initial begin
        logic found;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Phase A: reset state, first-fetch latency, zero-wait stream.
        lat         = 1;
        grant_total = 6;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", fetch_valid, 1'b0);
        check32("rst_inst", inst, BUBBLE);
        check32("rst_pc", pc, 32'h0);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        tick();
        rst = 1'b0;
        @(negedge clk);
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0);
        check1("c1_valid", fetch_valid, 1'b0);
        @(negedge clk);
        check1("c2_valid", fetch_valid, 1'b0);
        @(negedge clk);
        check1("c3_valid", fetch_valid, 1'b1);
        wait_drain("drain_a");

        // Phase B: three-cycle stall mid-stream; skid holds the next word.
        tick();
        grant_total += 8;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h18 + 32'(i * 4));
        wait_out("wait_20", 32'h20);
        tick();
        stall = 1'b1;
        @(negedge clk);
        check32("stall_hold0", pc, 32'h24);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            check1("stall_skid_req", imem_req, 1'b0);
            check32("stall_hold", pc, 32'h24);
        end
        tick();
        stall = 1'b0;
        wait_drain("drain_b");

        // Phase C: 3-cycle memory, redirect while a request is outstanding.
        tick();
        lat = 3;
        grant_total += 2;
        exp_q.push_back(32'h38);
        wait_out("wait_38", 32'h38);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect    = 1'b0;
        grant_total += 2;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        @(negedge clk);
        check1("drop_no_req", imem_req, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1) found = 1'b1;
        end
        check1("redir_req_seen", found, 1'b1);
        check32("redir_addr", imem_addr, 32'h100);
        wait_drain("drain_c");

        // Phase D: redirect coincides with rvalid while stalled.
        tick();
        lat = 1;
        grant_total += 3;
        exp_q.push_back(32'h108);
        wait_out("wait_108", 32'h108);
        tick();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        check32("pre_flush_pc", pc, 32'h10c);
        check1("redir_wait_req", imem_req, 1'b0);
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        grant_total += 1;
        exp_q.push_back(32'h100);
        @(negedge clk);
        check1("flush_valid", fetch_valid, 1'b0);
        check1("flush_req", imem_req, 1'b1);
        check32("flush_addr", imem_addr, 32'h100);
        wait_drain("drain_d");

        // Phase E: PC wraps past 0xFFFFFFFC.
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        grant_total += 3;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_gnt && imem_addr === 32'h0) found = 1'b1;
        end
        check1("wrap_addr_zero", found, 1'b1);
        wait_drain("drain_e");

        // Phase F: reset mid-WAIT, late response lands after reset.
        tick();
        lat = 3;
        grant_total += 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 && imem_gnt) found = 1'b1;
        end
        check1("f_req_seen", found, 1'b1);
        check32("f_req_addr", imem_addr, 32'h4);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check1("mid_rst_req", imem_req, 1'b0);
        check1("mid_rst_valid", fetch_valid, 1'b0);
        check32("mid_rst_inst", inst, BUBBLE);
        check32("mid_rst_pc", pc, 32'h0);
        tick();
        @(negedge clk);
        check1("mid_rst_req2", imem_req, 1'b0);
        tick();
        rst = 1'b0;
        grant_total += 1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        check1("restart_req", imem_req, 1'b1);
        check32("restart_addr", imem_addr, 32'h0);
        wait_drain("drain_f");
        repeat (8) @(negedge clk);
        check32("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
